uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter core between `N_REQ` byte-producing requesters (button handlers, message generators). It sits between the application logic and the UART TX core inside the UART TX application top. It accepts a byte from one requester at a time, issues a one-cycle start to the TX core and tracks the frame via the core's active flag. It enforces a configurable idle gap between frames.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART TX core between N_REQ byte producers.
// Optional WAIT_ACT watchdog: define UART_TX_ARB_TIMEOUT_EN to enable err_o and the timeout path.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      tx_start_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_active_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_W = (GAP_W > TO_W) ? GAP_W : TO_W;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;
  logic [N_REQ-1:0]   grant_d;
  logic               ld_win;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic               err_d;
`endif

  // Round-robin search: first requester after ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [PTR_W-1:0] kidx;
    win_vld = 1'b0;
    win_idx = ptr;
    kidx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      kidx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!win_vld && req_i[kidx]) begin
        win_vld = 1'b1;
        win_idx = kidx;
      end
    end
  end

  assign win_data = DATA_W'(data_i >> (int'(win_idx) * DATA_W));
  assign ld_win   = (state == S_IDLE) && win_vld;
  assign grant_d  = (state == S_START) ? (N_REQ'(1) << ptr) : '0;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (win_vld) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT_ACT;
        cnt_d   = '0;
      end
      S_WAIT_ACT: begin
        if (tx_active_i) begin
          state_d = S_WAIT_DONE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          err_d   = 1'b1;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      S_WAIT_DONE: begin
        if (!tx_active_i) begin
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_d = S_IDLE;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_d;
  end

  // Registered outputs: strobe/grant trail the START state by one clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr        <= PTR_W'(N_REQ - 1);
      cnt        <= '0;
      grant_o    <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      grant_o    <= grant_d;
      tx_start_o <= (state == S_START);
      busy_o     <= (state_d != S_IDLE);
      if (ld_win) begin
        ptr       <= win_idx;
        tx_data_o <= win_data;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_o <= 1'b0;
    else          err_o <= err_d;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: edge-count reference model plus directed literal checks.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 16;
  localparam int TO  = 32;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data = '0;
  logic            tx_active = 1'b0;
  logic [N-1:0]    grant;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            busy;
  logic            err;
  bit              stall = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dut_fall = -100;
  int gap_meas = -1;
  int last_start = -100;
  int last_err = -100;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data),
    .grant_o(grant), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .tx_active_i(tx_active), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: arbitration edges, frame-end edges and the gap, as plain edge arithmetic.
  initial begin : model
    int k, win, s_edge, idle_from, to_edge, phase, m_ptr;
    logic [N-1:0]  eg;
    logic [DW-1:0] edata;
    bit prev_act;
    prev_act = 1'b0; s_edge = -100; idle_from = 0; to_edge = -100;
    phase = 0; m_ptr = N - 1; edata = '0; k = 0; win = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (prev_act && !tx_active) dut_fall = cyc;
      prev_act = tx_active;
      if (!rst_n) begin
        m_ptr = N - 1; idle_from = cyc; phase = 0; edata = '0;
        s_edge = -100; to_edge = -100;
      end else if (phase == 1) begin
        if (cyc >= s_edge + 2) begin
          if (tx_active) phase = 2;
          else if (TO_EN && cyc == s_edge + 1 + TO) begin
            to_edge = cyc; idle_from = cyc + GAP; phase = 0;
          end
        end
      end else if (phase == 2) begin
        if (!tx_active) begin
          idle_from = cyc + GAP; phase = 0;
        end
      end else if (cyc > idle_from && req != '0) begin
        win = -1;
        for (int i = 1; i <= N; i++) begin
          k = (m_ptr + i) % N;
          if (win < 0 && bit'(req >> k)) win = k;
        end
        m_ptr = win;
        edata = DW'(data >> (win * DW));
        s_edge = cyc; idle_from = 32'h7fff_ffff; phase = 1;
      end
      @(negedge clk);
      eg = (cyc == s_edge + 1) ? (N'(1) << m_ptr) : '0;
      chk("grant", 32'(grant), 32'(eg));
      chk("tx_start", 32'(tx_start), 32'(cyc == s_edge + 1));
      chk("tx_data", 32'(tx_data), 32'(edata));
      chk("busy", 32'(busy), 32'(cyc < idle_from));
      chk("err", 32'(err), 32'(cyc == to_edge));
      if (tx_start) begin
        last_start = cyc;
        gap_meas = cyc - dut_fall;
      end
      if (err) last_err = cyc;
    end
  end

  // TX core stand-in: random start latency and frame length.
  initial begin : core
    int lat, len;
    forever begin
      @(negedge clk);
      if (tx_start && !stall) begin
        lat = $urandom_range(0, 3);
        len = $urandom_range(1, 12);
        repeat (lat) @(negedge clk);
        tx_active = 1'b1;
        repeat (len) @(negedge clk);
        tx_active = 1'b0;
      end
    end
  end

  task automatic wait_grant(input int budget, output logic [N-1:0] g, output int n);
    g = '0;
    n = 0;
    while (n < budget && g == '0) begin
      @(negedge clk); #1;
      n++;
      g = grant;
    end
    chk("grant_seen", 32'(g != '0), 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int extra);
    int n;
    n = 0;
    extra = 0;
    while (busy && n < budget) begin
      @(negedge clk); #1;
      n++;
      if (grant != '0) extra++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk); #1;
      if (grant != '0) extra++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [N-1:0] g;
    int n, extra;
    int exp_idx [5];
    exp_idx = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // single request
    req = 4'b0001;
    data[7:0] = 8'h41;
    wait_grant(20, g, n);
    chk("single_latency", 32'(n), 32'd2);
    chk("single_grant", 32'(g), 32'h1);
    chk("single_data", 32'(tx_data), 32'h41);
    chk("single_busy", 32'(busy), 32'd1);
    req = '0;
    wait_idle(200, extra);
    chk("single_extra", 32'(extra), 32'd0);

    // fairness and gap length
    do_reset();
    req = 4'b1111;
    data = {8'h33, 8'h32, 8'h31, 8'h30};
    for (int i = 0; i < 5; i++) begin
      wait_grant(200, g, n);
      chk("fair_grant", 32'(g), 32'(N'(1) << exp_idx[i]));
      chk("fair_data", 32'(tx_data), 32'(8'h30 + exp_idx[i]));
      if (i > 0) chk("gap_len", 32'(gap_meas), 32'(GAP + 2));
    end
    req = '0;
    wait_idle(200, extra);

    // sequential single requests
    for (int i = 0; i < 4; i++) begin
      req = N'(1) << i;
      data = N*DW'($urandom);
      wait_grant(50, g, n);
      chk("seq_grant", 32'(g), 32'(N'(1) << i));
      req = '0;
      wait_idle(200, extra);
      chk("seq_extra", 32'(extra), 32'd0);
    end

    // reset in the middle of a frame
    do_reset();
    req = 4'b1111;
    data = {8'h33, 8'h32, 8'h31, 8'h30};
    wait_grant(50, g, n);
    chk("pre_reset_grant", 32'(g), 32'h1);
    n = 0;
    while (!tx_active && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("frame_active", 32'(tx_active), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_start", 32'(tx_start), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    n = 0;
    while (tx_active && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_grant(20, g, n);
    chk("post_reset_grant", 32'(g), 32'h1);
    req = '0;
    wait_idle(200, extra);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // core never answers: watchdog fires, then the next grant follows the gap
    stall = 1'b1;
    req = 4'b0001;
    wait_grant(50, g, n);
    n = 0;
    while (!err && n < TO + 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("timeout_seen", 32'(err), 32'd1);
    chk("timeout_len", 32'(last_err - last_start), 32'(TO));
    stall = 1'b0;
    wait_grant(50, g, n);
    chk("timeout_regrant", 32'(last_start - last_err), 32'(GAP + 2));
    req = '0;
    wait_idle(200, extra);
`endif

    // random traffic under the requester contract
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (bit'(req >> k)) begin
          if (bit'(grant >> k)) begin
            if ($urandom_range(0, 1) == 0) req = req & ~(N'(1) << k);
            else data = (data & ~((N*DW)'(8'hff) << (k * DW))) | ((N*DW)'(8'($urandom)) << (k * DW));
          end else if ($urandom_range(0, 63) == 0) begin
            req = req & ~(N'(1) << k);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          data = (data & ~((N*DW)'(8'hff) << (k * DW))) | ((N*DW)'(8'($urandom)) << (k * DW));
          req = req | (N'(1) << k);
        end
      end
    end
    req = '0;
    wait_idle(500, extra);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
